// File: rtl/acc_cpu_pkg.sv
// Opcodes, FSM state type and decode helper shared by the acc_cpu_gen2 slice.
// Define CPU_MUL_EN to make opcode 4 a memory-operand MUL; otherwise it decodes as illegal.
package acc_cpu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_LOD = 4'd0;
  localparam logic [OP_W-1:0] OP_STO = 4'd1;
  localparam logic [OP_W-1:0] OP_ADD = 4'd2;
  localparam logic [OP_W-1:0] OP_SUB = 4'd3;
  localparam logic [OP_W-1:0] OP_MUL = 4'd4;
  localparam logic [OP_W-1:0] OP_AND = 4'd5;
  localparam logic [OP_W-1:0] OP_JMP = 4'd6;
  localparam logic [OP_W-1:0] OP_JMZ = 4'd7;
  localparam logic [OP_W-1:0] OP_NOP = 4'd8;
  localparam logic [OP_W-1:0] OP_HLT = 4'd9;
  localparam logic [OP_W-1:0] OP_OR  = 4'd10;
  localparam logic [OP_W-1:0] OP_XOR = 4'd11;
  localparam logic [OP_W-1:0] OP_JMN = 4'd12;
  localparam logic [OP_W-1:0] OP_JMC = 4'd13;
  localparam logic [OP_W-1:0] OP_LDI = 4'd14;
  localparam logic [OP_W-1:0] OP_ILL = 4'd15;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    HALT   = 3'd4
  } state_t;

  // Opcodes that read M[operand] in EXEC and complete in WB.
  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    case (op)
      OP_LOD, OP_STO, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: is_mem_op = 1'b1;
`ifdef CPU_MUL_EN
      OP_MUL: is_mem_op = 1'b1;
`endif
      default: is_mem_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational accumulator ALU for the WB stage; carry_we flags the ops that own the carry flag.
// The multiplier exists only when CPU_MUL_EN is defined.
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 10
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] operand,
  output logic [DATA_W-1:0] result,
  output logic              carry_out,
  output logic              carry_we
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, acc} + {1'b0, operand};
  // Top bit of the widened difference is the borrow (acc < operand).
  assign diff = {1'b0, acc} - {1'b0, operand};

`ifdef CPU_MUL_EN
  logic [2*DATA_W-1:0] prod;
  assign prod = (2*DATA_W)'(acc) * (2*DATA_W)'(operand);
`endif

  always_comb begin
    result    = acc;
    carry_out = 1'b0;
    carry_we  = 1'b0;
    case (op)
      OP_LOD: result = operand;
      OP_ADD: begin
        {carry_out, result} = sum;
        carry_we = 1'b1;
      end
      OP_SUB: begin
        {carry_out, result} = diff;
        carry_we = 1'b1;
      end
`ifdef CPU_MUL_EN
      OP_MUL: begin
        result    = prod[DATA_W-1:0];
        carry_out = |prod[2*DATA_W-1:DATA_W];
        carry_we  = 1'b1;
      end
`endif
      OP_AND: result = acc & operand;
      OP_OR:  result = acc | operand;
      OP_XOR: result = acc ^ operand;
      default: ;
    endcase
  end

endmodule

// File: rtl/acc_cpu_gen2.sv
// Second-generation accumulator CPU: FETCH/DECODE/EXEC/WB/HALT sequencer around acc_cpu_alu.
// Optional MUL instruction controlled by the CPU_MUL_EN macro.
module acc_cpu_gen2
  import acc_cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] acc,
  output logic              carry,
  output logic              halted,
  output logic              illegal
);

  if (DATA_W != OP_W + ADDR_W) begin : g_width_check
    $error("acc_cpu_gen2: DATA_W must equal 4 + ADDR_W");
  end

  state_t            state, state_next;
  logic [DATA_W-1:0] ir, ir_next;
  logic [ADDR_W-1:0] pc_next;
  logic [DATA_W-1:0] acc_next;
  logic              carry_next, illegal_next;

  logic [OP_W-1:0]   opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry, alu_carry_we;

  assign opcode  = ir[DATA_W-1 -: OP_W];
  assign operand = ir[ADDR_W-1:0];

  acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op        (opcode),
    .acc       (acc),
    .operand   (mem_rdata),
    .result    (alu_result),
    .carry_out (alu_carry),
    .carry_we  (alu_carry_we)
  );

  // State and architectural registers; reset overrides any pending store or halt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      pc      <= '0;
      ir      <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      ir      <= ir_next;
      acc     <= acc_next;
      carry   <= carry_next;
      halted  <= (state_next == HALT);
      illegal <= illegal_next;
    end
  end

  // Next-state, register updates and memory port drive.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    ir_next      = ir;
    acc_next     = acc;
    carry_next   = carry;
    illegal_next = illegal;
    mem_addr     = '0;
    mem_we       = 1'b0;
    mem_wdata    = '0;
    if (!rst) begin
      case (state)
        FETCH: begin
          mem_addr   = pc;
          state_next = DECODE;
        end
        DECODE: begin
          ir_next    = mem_rdata;
          pc_next    = pc + ADDR_W'(1);
          state_next = EXEC;
        end
        EXEC: begin
          state_next = FETCH;
          if (is_mem_op(opcode)) begin
            mem_addr   = operand;
            state_next = WB;
          end else begin
            case (opcode)
              OP_JMP: pc_next = operand;
              OP_JMZ: if (acc == '0) pc_next = operand;
              OP_JMN: if (acc[DATA_W-1]) pc_next = operand;
              OP_JMC: if (carry) pc_next = operand;
              OP_LDI: acc_next = DATA_W'(operand);
              OP_NOP: ;
              OP_HLT: state_next = HALT;
              default: begin
                illegal_next = 1'b1;
                state_next   = HALT;
              end
            endcase
          end
        end
        WB: begin
          if (opcode == OP_STO) begin
            mem_addr  = operand;
            mem_we    = 1'b1;
            mem_wdata = acc;
          end
          acc_next = alu_result;
          if (alu_carry_we) carry_next = alu_carry;
          state_next = FETCH;
        end
        HALT: ;
        default: state_next = FETCH;
      endcase
    end
  end

endmodule
